// File: rtl/interp_linear_if.sv
// Sample stream bundle for the linear interpolator: valid/ready input side, valid-only output side.
// Latency: none (wires only).
// Backpressure: data_i_rdy throttles the source; the output stream has no backpressure.
interface interp_linear_if #(
  parameter int D = 25
);
  logic         data_i_en;
  logic [D-1:0] data_i;
  logic         data_i_rdy;
  logic         data_o_en;
  logic [D-1:0] data_o;

  // Sample source / output sink side
  modport master (
    output data_i_en, data_i,
    input  data_i_rdy, data_o_en, data_o
  );

  // Interpolator side
  modport slave (
    input  data_i_en, data_i,
    output data_i_rdy, data_o_en, data_o
  );
endinterface

// File: rtl/interp_linear.sv
// Linear-interpolating upsampler by L = 2**log_L; optional round-half-up via INTERP_LINEAR_ROUND_EN.
// Latency: transfer on edge E gives outputs k=0..L-1 registered on edges E+1..E+L (seen valid E+2..E+L+1).
// Backpressure: data_i_rdy high in PRIME/READY and on the last RUN cycle only; output has none.
module interp_linear #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int log_L   = 2
) (
  input  logic           clk,
  input  logic           rst,
  interp_linear_if.slave io
);

  localparam int D  = width_H + width_W;
  localparam int L  = 1 << log_L;
  localparam int AW = D + log_L + 1;

`ifdef INTERP_LINEAR_ROUND_EN
  // Half an output LSB in accumulator units turns the floor slice into round-half-up
  localparam logic signed [AW-1:0] ACC_BIAS = AW'(L / 2);
`else
  localparam logic signed [AW-1:0] ACC_BIAS = '0;
`endif

  typedef enum logic [1:0] {PRIME, READY, RUN} state_t;

  state_t                 state_q, state_d;
  logic signed [D-1:0]    last_q, last_d;
  logic signed [D:0]      diff_q, diff_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [log_L-1:0]       cnt_q, cnt_d;
  logic                   data_o_en_q, data_o_en_d;
  logic [D-1:0]           data_o_q, data_o_d;

  logic                   rdy;
  logic                   xfer;
  logic                   cnt_last;
  logic signed [D-1:0]    x_s;
  logic signed [AW-1:0]   acc_load;

  assign cnt_last = &cnt_q;
  assign x_s      = $signed(io.data_i);
  assign xfer     = io.data_i_en && rdy;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PRIME;
    else      state_q <= state_d;
  end

  // Next-state: PRIME takes one sample, READY starts an interval, RUN chains or idles at the end
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   if (xfer) state_d = READY;
      READY:   if (xfer) state_d = RUN;
      RUN:     if (cnt_last && !xfer) state_d = READY;
      default: state_d = PRIME;
    endcase
  end

  // Ready decode: state and counter only (held low while reset is asserted)
  always_comb begin
    rdy = 1'b0;
    if (rst) rdy = (state_q != RUN) || cnt_last;
  end

  // Datapath next values: step the accumulator in RUN, reload on every accepted sample
  always_comb begin
    last_d      = last_q;
    diff_d      = diff_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    data_o_en_d = 1'b0;
    data_o_d    = data_o_q;
    acc_load    = (AW'(last_q) <<< log_L) + ACC_BIAS;
    if (state_q == RUN) begin
      data_o_en_d = 1'b1;
      data_o_d    = acc_q[D+log_L-1:log_L];
      acc_d       = acc_q + AW'(diff_q);
      cnt_d       = cnt_q + 1'b1;
    end
    if (xfer) begin
      last_d = x_s;
      if (state_q != PRIME) begin
        diff_d = (D+1)'(x_s) - (D+1)'(last_q);
        acc_d  = acc_load;
        cnt_d  = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q      <= '0;
      diff_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      data_o_en_q <= 1'b0;
      data_o_q    <= '0;
    end else begin
      last_q      <= last_d;
      diff_q      <= diff_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      data_o_en_q <= data_o_en_d;
      data_o_q    <= data_o_d;
    end
  end

  assign io.data_i_rdy = rdy;
  assign io.data_o_en  = data_o_en_q;
  assign io.data_o     = data_o_q;

endmodule

// File: tb/tb_interp_linear.sv
// Self-checking bench for interp_linear: scoreboard queue fed by a formula-level model.
// Latency: checks first output one cycle after the transfer-following negedge.
// Backpressure: source waits on data_i_rdy with a bounded cycle budget.
module tb_interp_linear;

  localparam int WH    = 5;
  localparam int WW    = 20;
  localparam int LOG_L = 2;
  localparam int D     = WH + WW;
  localparam int L     = 1 << LOG_L;
`ifdef INTERP_LINEAR_ROUND_EN
  localparam longint BIAS = L / 2;
`else
  localparam longint BIAS = 0;
`endif
  localparam longint SMAX = (longint'(1) << (D - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (D - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  interp_linear_if #(.D(D)) ifc ();

  interp_linear #(.width_H(WH), .width_W(WW), .log_L(LOG_L)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint exp_q[$];
  bit     primed = 0;
  longint prev = 0;
  int     cyc = 0;
  bit     win_on = 0;
  int     win_cnt = 0;
  int     win_first = 0;
  int     win_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint to_s(input logic [D-1:0] v);
    return longint'($signed(v));
  endfunction

  // Floor division for positive divisor
  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: L evenly spaced points from prev toward x, floored (or rounded half-up)
  task automatic accept(input longint x);
    if (primed) begin
      for (int k = 0; k < L; k++)
        exp_q.push_back(fdiv(prev * L + k * (x - prev) + BIAS, L));
    end
    prev   = x;
    primed = 1;
  endtask

  // Monitor: every valid output is popped and compared
  always @(negedge clk) begin
    if (rst && ifc.data_o_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0d, expected no output (cycle %0d)", to_s(ifc.data_o), cyc);
      end else begin
        check("data_o", to_s(ifc.data_o), exp_q.pop_front());
      end
      if (win_on) begin
        if (win_cnt == 0) win_first = cyc;
        win_last = cyc;
        win_cnt++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge with data_i_en low
  task automatic send(input longint x);
    int n;
    n = 0;
    ifc.data_i    = D'(x);
    ifc.data_i_en = 1'b1;
    while (!ifc.data_i_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.data_i_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: rdy=%0d after %0d cycles, expected 1", ifc.data_i_rdy, n);
      ifc.data_i_en = 1'b0;
      return;
    end
    @(posedge clk);
    accept(x);
    @(negedge clk);
    ifc.data_i_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic longint rand_sample();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return SMAX;
    if (sel == 1) return SMIN;
    return longint'($urandom_range(0, (1 << D) - 1)) + SMIN;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.data_i_en = 1'b0;
    ifc.data_i    = '0;
    rst           = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_o_en", longint'(ifc.data_o_en), 0);
    check("reset_o", to_s(ifc.data_o), 0);
    check("reset_rdy", longint'(ifc.data_i_rdy), 0);
    rst = 1'b1;
    @(negedge clk);
    check("prime_rdy", longint'(ifc.data_i_rdy), 1);

    // Ramp 0 -> 8, then latency of first output
    send(0);
    check("no_out_after_prime", longint'(ifc.data_o_en), 0);
    send(8);
    @(negedge clk);
    check("lat_o_en", longint'(ifc.data_o_en), 1);
    check("lat_k0", to_s(ifc.data_o), 0);
    send(9);
    drain();

    // Negative floor, then full-scale swing
    send(-4);
    send(3);
    send(SMAX);
    send(SMIN);
    drain();

    // Streaming with data_i_en held: outputs must be gapless
    win_cnt = 0;
    win_on  = 1;
    send(0);
    send(4);
    send(8);
    send(12);
    drain();
    win_on = 0;
    check("stream_count", win_cnt, 4 * L);
    check("stream_span", win_last - win_first + 1, win_cnt);

    // Asynchronous reset on the second RUN cycle
    send(100);
    send(200);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_o_en", longint'(ifc.data_o_en), 0);
    check("midrst_o", to_s(ifc.data_o), 0);
    check("midrst_rdy", longint'(ifc.data_i_rdy), 0);
    exp_q.delete();
    primed = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(500);
    check("post_rst_prime_no_out", longint'(ifc.data_o_en), 0);
    send(540);
    drain();

    // Randomized samples with random idle gaps
    for (int i = 0; i < 200; i++) begin
      send(rand_sample());
      repeat ($urandom_range(0, L + 2)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interp_linear.md
Name: interp_linear

Overview:
- Linear-interpolating upsampler by L = 2^log_L; the expansion-direction counterpart to the averaging/decimating filters in this library.
- Accepts signed fixed-point samples through a valid/ready handshake.
- Emits L evenly spaced samples per input interval as a continuous valid-strobed stream.
- Used ahead of DAC paths and filter test chains that need a higher sample rate.

Parameters:
- width_H, 5, integer bits of the signed sample.
- width_W, 20, fractional bits. D = width_H+width_W is the total sample width.
- log_L, 2, log2 of the interpolation factor. L = 2^log_L; log_L ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i_en  in  1  input sample valid.
- data_i  in  D  input sample, signed two's complement.
- data_i_rdy  out  1  block can accept a sample this cycle.
- data_o_en  out  1  output sample valid strobe; no backpressure.
- data_o  out  D  interpolated sample, signed.

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - data_o_en=0, data_o=0, data_i_rdy=0; state=PRIME.
  - last, acc, diff and cnt all 0.
- Transfer rule: a sample transfers on a rising edge where data_i_en && data_i_rdy. If data_i_en is high while data_i_rdy is low, the sample is ignored and the source holds it.
- Registers:
  - last: D bits, most recent accepted sample.
  - diff: D+1 bits, signed.
  - acc: D+log_L+1 bits, signed.
  - cnt: log_L bits.
- State PRIME:
  - data_i_rdy=1.
  - On transfer: last<=x, go to READY. No output is produced.
- State READY:
  - data_i_rdy=1.
  - On transfer: diff<=x-last (sign-extended to D+1 bits), acc<=last<<<log_L, last<=x, cnt<=0, go to RUN.
- State RUN, on each edge:
  - data_o_en<=1.
  - data_o<=acc>>>log_L (arithmetic shift, truncated to D bits; floor rounding).
  - acc<=acc+diff; cnt<=cnt+1.
- RUN exit, when cnt==L-1:
  - data_i_rdy=1 (combinational decode of state and cnt only; no path from data_i_en).
  - If a transfer occurs: reload diff/acc/last/cnt exactly as in READY and stay in RUN. This gives gapless output.
  - Otherwise go to READY.
- data_i_rdy=0 in RUN when cnt≠L-1. data_o_en<=0 on every edge not in RUN. data_o holds its last value when data_o_en=0.
- Latency:
  - Transfer on edge E → outputs k=0..L-1 on edges E+2..E+L+1.
  - Value of output k = floor(prev + k·(x−prev)/L), where prev is the sample accepted before x. Output k=0 equals prev exactly.
- Throughput: one input per L cycles. With data_i_en held high, data_o_en stays continuously high after the first interval.
- Width: outputs always lie between prev and x inclusive, so no overflow or saturation is possible. diff spans the full D+1-bit range, including full-scale max→min steps.
- Reset mid-RUN:
  - Remaining outputs are discarded and the block returns to PRIME.
  - The first sample after reset only primes the block.

Optional Feature:
- Macro: INTERP_LINEAR_ROUND_EN.
- Defined: the acc load becomes (last<<<log_L) + 2^(log_L−1). Each output is round-half-up of the exact interpolated value.
- Undefined: acc load as above; outputs floor the exact value.
- Latency, handshake and k=0 output are identical in both builds.

Test Plan:
- Prime 0, then send 8 (D=25, log_L=2) → data_o = 0,2,4,6 on consecutive data_o_en cycles. The first sample produces no output.
- Continue with 9 after 8 → 8,8,8,8. With INTERP_LINEAR_ROUND_EN defined → 8,8,9,9.
- Prime −4, then send 3 → −4,−3,−1,1. Checks negative floor and sign extension.
- Prime 2^24−1, then send −2^24 → 2^24−1, 2^23−1, −1, −2^23−1. Checks full-scale diff with no overflow.
- Hold data_i_en high with samples 0,4,8,12 → data_i_rdy pulses once per 4 cycles after READY; data_o_en is gapless (0..3, 4..7, 8..11); no sample is dropped or duplicated.
- Assert rst low on the second RUN cycle → outputs go to 0 immediately (async); data_i_rdy=0 during reset. After release, the next sample only primes; the following sample yields a fresh interpolation starting from it.
